tc_rom_arbiter: RTL and testbench
=================================

Name: tc_rom_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the single read port of the file-backed ROM (TC_FileRom).
- Sits between two requesters (port 0 = instruction fetch, port 1 = data load) and the ROM.
- Serialises their 64-bit read requests and drives the ROM en/address inputs at the correct cycle.
- Captures the registered ROM output and returns it with a one-cycle valid pulse to the owning requester.
- Rejects out-of-range addresses without touching the ROM.

Parameters:
MEM_BYTES, 65536, ROM byte capacity; an access is in range when addr+7 < MEM_BYTES.
SIZE_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, size-query address; always forwarded to the ROM, never range-checked.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
req0  in  1  port 0 request; held with addr0 until ack0.
addr0  in  64  port 0 byte address.
ack0  out  1  one-cycle pulse: port 0 request accepted.
rvalid0  out  1  one-cycle pulse: rdata0/rerr0 valid.
rdata0  out  64  port 0 read data.
rerr0  out  1  port 0 out-of-range flag, qualified by rvalid0.
req1, addr1, ack1, rvalid1, rdata1, rerr1  (same as port 0, for port 1).
rom_en  out  1  to ROM en.
rom_address  out  64  to ROM address.
rom_out  in  64  from ROM out; registered by the ROM, valid the cycle after it samples en=1.

Behaviour:
Reset (rst=0, async):
- Outputs zero: ack*, rvalid*, rdata*, rerr*, rom_en, rom_address.
- state=IDLE; last_owner=1, so port 0 wins the first tie.
- Any in-flight transaction is dropped; no rvalid follows release of reset.

All outputs are registered.

FSM states: IDLE, ISSUE, WAIT.

IDLE:
- If neither request is asserted, stay in IDLE.
- If exactly one request is asserted, grant that port.
- If both are asserted, grant the port != last_owner.
- On a grant, at the clock edge:
  - latch owner and addr; set last_owner=owner; pulse ack<owner>=1 for the next cycle.
  - compute oor = (addr != SIZE_ADDR) && (addr > MEM_BYTES-8), in 65-bit arithmetic so there is no wrap.
  - rom_address<=addr.
  - rom_en<=!oor.
  - go to ISSUE.

ISSUE:
- The ROM samples en/address at the end of this cycle.
- At the edge: rom_en<=0; rom_address is held; go to WAIT.

WAIT:
- rom_out is valid in this cycle.
- At the edge: rdata<owner> <= oor ? 0 : rom_out; rerr<owner> <= oor; rvalid<owner> <= 1; go to IDLE.

Timing:
- Request sampled at edge k gives ack in cycle k+1, rom_en in cycle k+1, and rvalid/rdata in cycle k+3.
- The next grant is possible at edge k+3, so peak throughput is 1 read per 3 cycles.

Requests and ack:
- Requests are ignored outside IDLE.
- Because a requester drops or changes req after seeing ack, a held req is never double-granted.

Output hold:
- rdata*/rerr* hold their values until the next completion on the same port.
- rvalid and ack are exactly 1 cycle wide.
- rvalid0 and rvalid1 are never high together; ack0 and ack1 are never high together.

Other rules:
- Port-to-port priority is strictly alternating under continuous contention.
- rom_en is high for exactly one cycle per in-range transaction and is never high otherwise. The ROM zeroes its output when en=0, so capture happens only in WAIT.

Test Plan:
1. Reset, then req0=1, addr0=0x10 with ROM bytes 0x10..0x17 = 01..08 -> ack0 in cycle 1; rom_en=1, rom_address=0x10 in cycle 1; rvalid0 in cycle 3 with rdata0=0x0807060504030201, rerr0=0.
2. req0 and req1 both held high continuously, with ack-driven address updates -> grant order 0,1,0,1; ack pulses 3 cycles apart; rvalid0/rvalid1 never coincide.
3. addr1=MEM_BYTES-7 -> rom_en stays 0; rvalid1 with rdata1=0, rerr1=1. addr1=MEM_BYTES-8 -> normal read, rerr1=0.
4. addr0=SIZE_ADDR with FILE_BYTES=302 -> rom_en pulses; rdata0=302, rerr0=0.
5. rst driven low in WAIT, asynchronous to clk -> all outputs 0 immediately; no rvalid after release; the next req0 is granted normally with port 0 winning a tie.
6. req1 held during port 0's ISSUE/WAIT cycles -> no ack1 until the FSM returns to IDLE; then ack1 exactly once.

Source files
------------

// File: rtl/tc_rom_arbiter.sv
// Two-port round-robin sequencer for the single read port of a registered ROM.
// Each grant issues one ROM read (or rejects it as out of range) and returns data three cycles later.
module tc_rom_arbiter #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [63:0] SIZE_ADDR = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [63:0] addr0,
  output logic        ack0,
  output logic        rvalid0,
  output logic [63:0] rdata0,
  output logic        rerr0,
  input  logic        req1,
  input  logic [63:0] addr1,
  output logic        ack1,
  output logic        rvalid1,
  output logic [63:0] rdata1,
  output logic        rerr1,
  output logic        rom_en,
  output logic [63:0] rom_address,
  input  logic [63:0] rom_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Highest legal start address of an 8-byte read, widened so addr+7 cannot wrap.
  localparam logic [64:0] LAST_START = 65'(MEM_BYTES) - 65'd8;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic        oor_reg, oor_next;
  logic        ack0_next, ack1_next;
  logic        rvalid0_next, rvalid1_next;
  logic [63:0] rdata0_next, rdata1_next;
  logic        rerr0_next, rerr1_next;
  logic        rom_en_next;
  logic [63:0] rom_address_next;

  logic        grant_valid;
  logic        grant_port;
  logic [63:0] grant_addr;
  logic        grant_oor;

  // On a tie the port that was not served last wins.
  assign grant_valid = req0 | req1;
  assign grant_port  = (req0 & req1) ? ~last_reg : req1;
  assign grant_addr  = grant_port ? addr1 : addr0;
  assign grant_oor   = (grant_addr != SIZE_ADDR) && ({1'b0, grant_addr} > LAST_START);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      last_reg    <= 1'b1;
      oor_reg     <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      rerr0       <= 1'b0;
      rerr1       <= 1'b0;
      rom_en      <= 1'b0;
      rom_address <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      oor_reg     <= oor_next;
      ack0        <= ack0_next;
      ack1        <= ack1_next;
      rvalid0     <= rvalid0_next;
      rvalid1     <= rvalid1_next;
      rdata0      <= rdata0_next;
      rdata1      <= rdata1_next;
      rerr0       <= rerr0_next;
      rerr1       <= rerr1_next;
      rom_en      <= rom_en_next;
      rom_address <= rom_address_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_next        = last_reg;
    oor_next         = oor_reg;
    ack0_next        = 1'b0;
    ack1_next        = 1'b0;
    rvalid0_next     = 1'b0;
    rvalid1_next     = 1'b0;
    rdata0_next      = rdata0;
    rdata1_next      = rdata1;
    rerr0_next       = rerr0;
    rerr1_next       = rerr1;
    rom_en_next      = 1'b0;
    rom_address_next = rom_address;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next       = grant_port;
          last_next        = grant_port;
          oor_next         = grant_oor;
          ack0_next        = ~grant_port;
          ack1_next        = grant_port;
          rom_address_next = grant_addr;
          rom_en_next      = ~grant_oor;
          state_next       = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // ROM output is only non-zero in this cycle, so capture happens here alone.
        if (owner_reg) begin
          rvalid1_next = 1'b1;
          rdata1_next  = oor_reg ? 64'd0 : rom_out;
          rerr1_next   = oor_reg;
        end else begin
          rvalid0_next = 1'b1;
          rdata0_next  = oor_reg ? 64'd0 : rom_out;
          rerr0_next   = oor_reg;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tc_rom_arbiter.sv
// Self-checking bench for tc_rom_arbiter: ROM stand-in, transaction-level model and per-cycle compare.
module tb_tc_rom_arbiter;
  localparam int unsigned MEM_BYTES  = 65536;
  localparam logic [63:0] SIZE_ADDR  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FILE_BYTES = 64'd302;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0;
  logic        ack0, ack1, rvalid0, rvalid1, rerr0, rerr1, rom_en;
  logic [63:0] rdata0, rdata1, rom_address;
  logic [63:0] rom_out = '0;

  logic [7:0]  mem [MEM_BYTES];

  int tests = 0;
  int fails = 0;

  tc_rom_arbiter #(.MEM_BYTES(MEM_BYTES), .SIZE_ADDR(SIZE_ADDR)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0), .rerr0(rerr0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1), .rerr1(rerr1),
    .rom_en(rom_en), .rom_address(rom_address), .rom_out(rom_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd64(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    if (a > 64'(MEM_BYTES - 8)) return 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = mem[int'(a[31:0]) + i];
    return r;
  endfunction

  function automatic logic [63:0] rom_val(input logic [63:0] a);
    if (a == SIZE_ADDR) return FILE_BYTES;
    return rd64(a);
  endfunction

  // Registered ROM: data appears the cycle after en=1, zero otherwise.
  always @(posedge clk) begin
    if (rom_en) rom_out <= rom_val(rom_address);
    else        rom_out <= '0;
  end

  // Transaction-level model.
  longint      cyc, free_edge, done_edge;
  int          last_owner, cur_owner;
  logic [63:0] cur_addr;
  logic        cur_oor;
  logic        e_ack0, e_ack1, e_rv0, e_rv1, e_rerr0, e_rerr1, e_en;
  logic [63:0] e_rd0, e_rd1, e_addr;

  int          ack1_cnt = 0;

  task automatic model_reset();
    cyc = 0; free_edge = 0; done_edge = -1;
    last_owner = 1; cur_owner = 0; cur_addr = '0; cur_oor = 1'b0;
    e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0; e_rerr0 = 0; e_rerr1 = 0; e_en = 0;
    e_rd0 = '0; e_rd1 = '0; e_addr = '0;
  endtask

  task automatic model_edge();
    cyc++;
    e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0; e_en = 0;
    if (cyc == done_edge) begin
      if (cur_owner == 0) begin
        e_rv0 = 1; e_rd0 = cur_oor ? 64'd0 : rom_val(cur_addr); e_rerr0 = cur_oor;
      end else begin
        e_rv1 = 1; e_rd1 = cur_oor ? 64'd0 : rom_val(cur_addr); e_rerr1 = cur_oor;
      end
    end
    if (cyc >= free_edge && (req0 || req1)) begin
      int g;
      g = (req0 && req1) ? 1 - last_owner : (req0 ? 0 : 1);
      cur_owner  = g;
      last_owner = g;
      cur_addr   = (g == 1) ? addr1 : addr0;
      cur_oor    = (cur_addr != SIZE_ADDR) && (({1'b0, cur_addr} + 65'd7) >= 65'(MEM_BYTES));
      if (g == 0) e_ack0 = 1; else e_ack1 = 1;
      e_en      = !cur_oor;
      e_addr    = cur_addr;
      done_edge = cyc + 2;
      free_edge = cyc + 3;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    chk("rerr0", rerr0, e_rerr0);
    chk("rerr1", rerr1, e_rerr1);
    chk("rom_en", rom_en, e_en);
    chk("rom_address", rom_address, e_addr);
    if (ack1) ack1_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare();
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return SIZE_ADDR;
      1: return 64'(MEM_BYTES - 8);
      2: return 64'(MEM_BYTES - 7);
      3: return {$urandom, $urandom};
      4: return 64'hFFFF_FFFF_FFFF_FFF9;
      default: return 64'($urandom_range(0, MEM_BYTES - 8));
    endcase
  endfunction

  initial begin
    int order[$];
    int gcyc[$];
    int n;
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) mem[int'(MEM_BYTES) - 8 + i] = 8'(8'hA0 + i);
    model_reset();

    // Reset state
    repeat (2) cycle();
    chk("rst_rom_en", rom_en, 0);
    chk("rst_ack0", ack0, 0);
    #2 rst = 1'b1;

    // Single read of bytes 01..08 at 0x10
    req0 = 1; addr0 = 64'h10;
    cycle();
    chk("t1_ack0", ack0, 1);
    chk("t1_rom_en", rom_en, 1);
    chk("t1_rom_addr", rom_address, 64'h10);
    req0 = 0;
    cycle();
    cycle();
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 64'h0807060504030201);
    chk("t1_rerr0", rerr0, 0);

    // Range boundaries on port 1
    req1 = 1; addr1 = 64'(MEM_BYTES - 7);
    cycle();
    chk("t3_ack1", ack1, 1);
    chk("t3_oor_en", rom_en, 0);
    req1 = 0;
    cycle();
    chk("t3_oor_en2", rom_en, 0);
    cycle();
    chk("t3_rvalid1", rvalid1, 1);
    chk("t3_rdata1", rdata1, 0);
    chk("t3_rerr1", rerr1, 1);
    req1 = 1; addr1 = 64'(MEM_BYTES - 8);
    cycle();
    chk("t3_last_en", rom_en, 1);
    req1 = 0;
    cycle();
    cycle();
    chk("t3_last_data", rdata1, 64'hA7A6A5A4A3A2A1A0);
    chk("t3_last_rerr", rerr1, 0);

    // Size query
    req0 = 1; addr0 = SIZE_ADDR;
    cycle();
    chk("t4_rom_en", rom_en, 1);
    req0 = 0;
    cycle();
    cycle();
    chk("t4_rvalid0", rvalid0, 1);
    chk("t4_rdata0", rdata0, 302);
    chk("t4_rerr0", rerr0, 0);

    // Port 1 request raised while port 0 is in flight
    req0 = 1; addr0 = 64'h40;
    cycle();
    req0 = 0; req1 = 1; addr1 = 64'h100;
    n = ack1_cnt;
    cycle();
    chk("t6_no_ack1_issue", ack1, 0);
    cycle();
    chk("t6_no_ack1_wait", ack1, 0);
    cycle();
    chk("t6_ack1", ack1, 1);
    req1 = 0;
    repeat (3) cycle();
    chk("t6_ack1_once", 64'(ack1_cnt - n), 1);

    // Continuous contention
    addr0 = 64'($urandom_range(0, MEM_BYTES - 8));
    addr1 = 64'($urandom_range(0, MEM_BYTES - 8));
    req0 = 1; req1 = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (ack0) begin order.push_back(0); gcyc.push_back(int'(cyc)); addr0 = 64'($urandom_range(0, MEM_BYTES - 8)); end
      if (ack1) begin order.push_back(1); gcyc.push_back(int'(cyc)); addr1 = 64'($urandom_range(0, MEM_BYTES - 8)); end
    end
    req0 = 0; req1 = 0;
    repeat (3) cycle();
    chk("t2_grants", 64'(order.size()), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("t2_order", 64'(order[i]), 64'(i % 2));
    for (int i = 1; i < gcyc.size(); i++) chk("t2_gap", 64'(gcyc[i] - gcyc[i-1]), 3);

    // Asynchronous reset while in WAIT
    req0 = 1; addr0 = 64'h20;
    cycle();
    req0 = 0;
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("t5_rom_address", rom_address, 0);
    chk("t5_rdata0", rdata0, 0);
    chk("t5_rdata1", rdata1, 0);
    chk("t5_rvalid0", rvalid0, 0);
    model_reset();
    repeat (2) cycle();
    #3 rst = 1'b1;
    repeat (3) cycle();
    req0 = 1; req1 = 1; addr0 = 64'h30; addr1 = 64'h38;
    cycle();
    chk("t5_tie_ack0", ack0, 1);
    chk("t5_tie_ack1", ack1, 0);
    req0 = 0; req1 = 0;
    repeat (3) cycle();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (ack0) begin
        if ($urandom_range(0, 1) == 1) addr0 = rand_addr(); else req0 = 0;
      end else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; addr0 = rand_addr();
      end
      if (ack1) begin
        if ($urandom_range(0, 1) == 1) addr1 = rand_addr(); else req1 = 0;
      end else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; addr1 = rand_addr();
      end
    end
    req0 = 0; req1 = 0;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
